// File: rtl/link_ddr_downstream_rx_ch_if.sv
// Bus bundle for one downstream link channel: io beat input, core-side
// valid/yumi word port, token return and status flags.
interface link_ddr_downstream_rx_ch_if #(
    parameter int CH_W       = 8,
    parameter int BEATS      = 4,
    parameter int FIFO_DEPTH = 8
) ();
    localparam int WORD_W = CH_W * BEATS;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    logic              io_valid_i;
    logic [CH_W-1:0]   io_data_i;
    logic [WORD_W-1:0] core_data_o;
    logic              core_valid_o;
    logic              core_yumi_i;
    logic              token_clk_o;
    logic              token_o;
    logic [CNT_W-1:0]  count_o;
    logic              overflow_o;
    logic              proto_err_o;

    // Environment side: link beats in, core consume strobe in.
    modport master (
        output io_valid_i, io_data_i, core_yumi_i,
        input  core_data_o, core_valid_o, token_clk_o, token_o,
               count_o, overflow_o, proto_err_o
    );

    // Receiver side.
    modport slave (
        input  io_valid_i, io_data_i, core_yumi_i,
        output core_data_o, core_valid_o, token_clk_o, token_o,
               count_o, overflow_o, proto_err_o
    );
endinterface

// File: rtl/link_ddr_downstream_rx_ch.sv
// Receive side of one link channel: assembles BEATS io beats into a word,
// buffers words in a FIFO for a valid/yumi consumer and returns one credit
// token to the upstream sender every TOKEN_DEC dequeued words.
// BEATS must be >= 2 (the final beat bypasses the partial-word register).
module link_ddr_downstream_rx_ch #(
    parameter int CH_W       = 8,
    parameter int BEATS      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TOKEN_DEC  = 2
) (
    input logic clk,
    input logic rst,
    link_ddr_downstream_rx_ch_if.slave bus
);
    localparam int WORD_W = CH_W * BEATS;
    localparam int PART_W = WORD_W - CH_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BC_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TC_W   = (TOKEN_DEC > 1) ? $clog2(TOKEN_DEC) : 1;

    logic [BC_W-1:0]   beat_cnt;
    logic [PART_W-1:0] part_q;
    logic [WORD_W-1:0] word_asm;
    logic              last_beat;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [CNT_W-1:0]  count;
    logic              not_empty, full, enq, deq;

    logic [TC_W-1:0]   tok_cnt;
    logic              tok_wrap;
    logic              token_q, token_clk_q;
    logic              overflow_q, proto_err_q;

    // Final beat is taken straight from the io bus so the word enqueues on
    // the same edge that accepts its last beat.
    assign last_beat = bus.io_valid_i && (beat_cnt == BC_W'(BEATS - 1));
    assign word_asm  = {bus.io_data_i, part_q};

    assign not_empty = (count != '0);
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign deq       = bus.core_yumi_i && not_empty;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign enq       = last_beat && (!full || deq);
    assign tok_wrap  = deq && (tok_cnt == TC_W'(TOKEN_DEC - 1));

    // Beat counter and partial-word capture; idle cycles hold state.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            part_q   <= '0;
        end else if (bus.io_valid_i) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + BC_W'(1);
            for (int k = 0; k < BEATS - 1; k++)
                if (beat_cnt == BC_W'(k))
                    part_q[k*CH_W +: CH_W] <= bus.io_data_i;
        end
    end

    // Word storage; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (enq)
            mem[wptr] <= word_asm;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq) wptr <= wptr + PTR_W'(1);
            if (deq) rptr <= rptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags: dropped word, yumi while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            if (last_beat && !enq)                  overflow_q  <= 1'b1;
            if (bus.core_yumi_i && !not_empty)      proto_err_q <= 1'b1;
        end
    end

    // Credit return: one token per TOKEN_DEC accepted dequeues.
    always_ff @(posedge clk) begin
        if (rst) begin
            tok_cnt     <= '0;
            token_q     <= 1'b0;
            token_clk_q <= 1'b0;
        end else begin
            if (deq) tok_cnt <= tok_wrap ? '0 : tok_cnt + TC_W'(1);
            token_q     <= tok_wrap;
            token_clk_q <= token_clk_q ^ tok_wrap;
        end
    end

    assign bus.core_valid_o = not_empty;
    assign bus.core_data_o  = not_empty ? mem[rptr] : '0;
    assign bus.count_o      = count;
    assign bus.overflow_o   = overflow_q;
    assign bus.proto_err_o  = proto_err_q;
    assign bus.token_o      = token_q;
    assign bus.token_clk_o  = token_clk_q;
endmodule

// File: tb/tb_link_ddr_downstream_rx_ch.sv
// Bench for link_ddr_downstream_rx_ch: vector table for word assembly plus
// hand sequences for fill/overflow, full+yumi, tokens, errors and reset.
// Expected words live in a scoreboard queue pushed at stimulus time.
module tb_link_ddr_downstream_rx_ch;
    localparam int DEPTH = 8;
    localparam int TD    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    link_ddr_downstream_rx_ch_if #(.CH_W(8), .BEATS(4), .FIFO_DEPTH(DEPTH)) bus ();

    link_ddr_downstream_rx_ch #(
        .CH_W(8), .BEATS(4), .FIFO_DEPTH(DEPTH), .TOKEN_DEC(TD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        int          gap;
        logic [31:0] exp;
    } vec_t;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] sb[$];
    int          mcnt = 0;
    int          tok = 0;
    logic        exp_tok = 1'b0;
    logic        exp_tclk = 1'b0;
    logic        exp_ovf = 1'b0;
    int          tok_pulses = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Model of one accepted dequeue: scoreboard, occupancy and token counter.
    task automatic model_deq();
        void'(sb.pop_front());
        mcnt--;
        if (tok == TD - 1) begin
            tok = 0; exp_tok = 1'b1; exp_tclk = ~exp_tclk;
        end else begin
            tok++; exp_tok = 1'b0;
        end
    endtask

    task automatic chk_tokens(input string nm);
        chk({nm, "_token"}, {31'd0, bus.token_o}, {31'd0, exp_tok});
        chk({nm, "_tclk"}, {31'd0, bus.token_clk_o}, {31'd0, exp_tclk});
        if (bus.token_o) tok_pulses++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.io_valid_i = 1'b0; bus.io_data_i = '0; bus.core_yumi_i = 1'b0;
        tick(); tick();
        chk("rst_valid", {31'd0, bus.core_valid_o}, 0);
        chk("rst_data", bus.core_data_o, 0);
        chk("rst_count", {28'd0, bus.count_o}, 0);
        chk("rst_flags", {28'd0, bus.overflow_o, bus.proto_err_o, bus.token_o, bus.token_clk_o}, 0);
        rst = 1'b0;
        sb.delete(); mcnt = 0; tok = 0;
        exp_tok = 1'b0; exp_tclk = 1'b0; exp_ovf = 1'b0;
    endtask

    // Drive one word's beats; optionally raise yumi alongside the last beat.
    task automatic send(input logic [7:0] b0, b1, b2, b3, input int gap,
                        input logic [31:0] exp, input bit yumi_last);
        logic [7:0] bb[4];
        bb = '{b0, b1, b2, b3};
        for (int k = 0; k < 4; k++) begin
            bus.io_valid_i = 1'b1;
            bus.io_data_i  = bb[k];
            if (k == 3) begin
                chk("pre_valid", {31'd0, bus.core_valid_o}, {31'd0, mcnt != 0});
                if (yumi_last) begin
                    chk("yumi_head", bus.core_data_o, sb[0]);
                    bus.core_yumi_i = 1'b1;
                end
            end
            tick();
            bus.io_valid_i = 1'b0;
            bus.core_yumi_i = 1'b0;
            if (k == 3) begin
                if (yumi_last) begin
                    model_deq();
                    chk_tokens("yumi_last");
                end
                if (mcnt < DEPTH) begin sb.push_back(exp); mcnt++; end
                else exp_ovf = 1'b1;
            end else begin
                repeat (gap) tick();
            end
        end
    endtask

    task automatic pop(input string nm);
        chk({nm, "_valid"}, {31'd0, bus.core_valid_o}, 1);
        if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL %s_sb: got empty scoreboard expected entry", nm);
        end else begin
            chk({nm, "_data"}, bus.core_data_o, sb[0]);
            bus.core_yumi_i = 1'b1;
            tick();
            bus.core_yumi_i = 1'b0;
            model_deq();
            chk_tokens(nm);
        end
    endtask

    vec_t vt[4];

    initial begin
        vt[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 0, 32'h44332211};
        vt[1] = '{8'h11, 8'h22, 8'h33, 8'h44, 2, 32'h44332211};
        vt[2] = '{8'hde, 8'had, 8'hbe, 8'hef, 1, 32'hefbeadde};
        vt[3] = '{8'h00, 8'hff, 8'h00, 8'hff, 0, 32'hff00ff00};

        // Reset then 10 idle cycles.
        do_reset();
        repeat (10) tick();
        chk("idle_valid", {31'd0, bus.core_valid_o}, 0);
        chk("idle_count", {28'd0, bus.count_o}, 0);
        chk("idle_flags", {30'd0, bus.token_o, bus.token_clk_o}, 0);

        // Assembly vectors.
        foreach (vt[i]) begin
            send(vt[i].b0, vt[i].b1, vt[i].b2, vt[i].b3, vt[i].gap, vt[i].exp, 1'b0);
            chk("asm_count", {28'd0, bus.count_o}, 1);
            pop("asm");
            chk("asm_empty", {28'd0, bus.count_o}, 0);
        end

        // Fill to depth, drop the 9th, drain in order.
        for (int i = 1; i <= 8; i++) send(8'(i), 8'h0, 8'h0, 8'h0, 0, 32'(i), 1'b0);
        chk("fill_count", {28'd0, bus.count_o}, 8);
        chk("fill_ovf", {31'd0, bus.overflow_o}, 0);
        send(8'h09, 8'h0, 8'h0, 8'h0, 0, 32'h9, 1'b0);
        chk("ovf_flag", {31'd0, bus.overflow_o}, {31'd0, exp_ovf});
        chk("ovf_count", {28'd0, bus.count_o}, 8);
        for (int i = 0; i < 8; i++) pop("drain");
        chk("drain_count", {28'd0, bus.count_o}, 0);
        chk("ovf_sticky", {31'd0, bus.overflow_o}, 1);

        // Full FIFO with yumi on the completing beat: nothing dropped.
        do_reset();
        for (int i = 1; i <= 8; i++) send(8'(i), 8'h0, 8'h0, 8'h0, 0, 32'(i), 1'b0);
        send(8'h09, 8'h0, 8'h0, 8'h0, 0, 32'h9, 1'b1);
        chk("fy_count", {28'd0, bus.count_o}, 8);
        chk("fy_ovf", {31'd0, bus.overflow_o}, 0);
        for (int i = 0; i < 8; i++) pop("fy_drain");
        chk("fy_empty", {28'd0, bus.count_o}, 0);

        // Tokens: 4 dequeues from fresh reset give 2 pulses, clock back at 0.
        do_reset();
        tok_pulses = 0;
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 8'h20, 8'h30, 8'h40, 0, {8'h40, 8'h30, 8'h20, 8'h10 + 8'(i)}, 1'b0);
        pop("tok1");
        pop("tok2");
        chk("tok2_pulse", {31'd0, bus.token_o}, 1);
        tick();
        chk("tok2_drop", {31'd0, bus.token_o}, 0);
        pop("tok3");
        pop("tok4");
        tick();
        chk("tok_pulses", 32'(tok_pulses), 2);
        chk("tok_clk_end", {31'd0, bus.token_clk_o}, 0);

        // Yumi while empty.
        bus.core_yumi_i = 1'b1;
        tick();
        bus.core_yumi_i = 1'b0;
        chk("perr_flag", {31'd0, bus.proto_err_o}, 1);
        chk("perr_count", {28'd0, bus.count_o}, 0);
        chk("perr_token", {31'd0, bus.token_o}, 0);

        // Reset in the middle of a word discards the partial beats.
        bus.io_valid_i = 1'b1; bus.io_data_i = 8'h55; tick();
        bus.io_data_i = 8'h66; tick();
        do_reset();
        send(8'haa, 8'hbb, 8'hcc, 8'hdd, 0, 32'hddccbbaa, 1'b0);
        chk("mid_flags", {30'd0, bus.overflow_o, bus.proto_err_o}, 0);
        chk("mid_count", {28'd0, bus.count_o}, 1);
        pop("mid");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
